// File: rtl/toggle_period_meter_if.sv
// Signal bundle between a toggling source and the toggle_period_meter.
// The source drives sig_in; the meter returns its measurement and status flags.
interface toggle_period_meter_if #(
  parameter int CNT_W = 26
) ();
  logic             sig_in;
  logic [CNT_W-1:0] half_period;
  logic             period_vld;
  logic             locked;
  logic             stalled;

  modport master (
    output sig_in,
    input  half_period,
    input  period_vld,
    input  locked,
    input  stalled
  );

  modport slave (
    input  sig_in,
    output half_period,
    output period_vld,
    output locked,
    output stalled
  );
endinterface

// File: rtl/toggle_period_meter.sv
// Measures edge-to-edge intervals of an asynchronous square wave in sys_clk cycles,
// and reports lock against an expected half-period plus a stall flag when edges stop.
module toggle_period_meter #(
  parameter int               CNT_W       = 26,
  parameter logic [CNT_W-1:0] EXP_HALF    = 26'd25_000_000,
  parameter logic [CNT_W-1:0] TOL         = 26'd1000,
  parameter int               LOCK_N      = 4,
  parameter logic [CNT_W-1:0] TIMEOUT_MAX = 26'd49_999_999
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  toggle_period_meter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_t;

  // Match window bounds are one bit wider so EXP_HALF+TOL cannot wrap.
  localparam logic [CNT_W:0] HI_BOUND = {1'b0, EXP_HALF} + {1'b0, TOL};
  localparam logic [CNT_W:0] LO_BOUND = (TOL > EXP_HALF) ? {(CNT_W+1){1'b0}}
                                                         : ({1'b0, EXP_HALF} - {1'b0, TOL});
  localparam logic [3:0]     LOCK_TGT = 4'(LOCK_N);

  state_t           state_r;
  logic             sync1_r;
  logic             sync2_r;
  logic             hist_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       match_cnt_r;
  logic [CNT_W-1:0] half_period_r;
  logic             period_vld_r;
  logic             locked_r;
  logic             stalled_r;

  logic             edge_det_s;
  logic [CNT_W:0]   cnt_inc_s;
  logic             match_s;
  logic [3:0]       match_next_s;
  logic             lock_next_s;

  // Edge detect, interval-plus-one, and the lock bookkeeping for a measuring edge.
  always_comb begin
    edge_det_s   = sync2_r ^ hist_r;
    cnt_inc_s    = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    match_s      = (cnt_inc_s >= LO_BOUND) && (cnt_inc_s <= HI_BOUND);
    match_next_s = 4'd0;
    lock_next_s  = 1'b0;
    if (match_s) begin
      if (match_cnt_r >= LOCK_TGT) begin
        match_next_s = LOCK_TGT;
      end else begin
        match_next_s = match_cnt_r + 4'd1;
      end
      lock_next_s = (match_next_s == LOCK_TGT);
    end else begin
      match_next_s = 4'd0;
      lock_next_s  = 1'b0;
    end
  end

  // Synchronizer, measurement FSM and all registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r       <= IDLE;
      sync1_r       <= 1'b0;
      sync2_r       <= 1'b0;
      hist_r        <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
      match_cnt_r   <= 4'd0;
      half_period_r <= {CNT_W{1'b0}};
      period_vld_r  <= 1'b0;
      locked_r      <= 1'b0;
      stalled_r     <= 1'b0;
    end else begin
      sync1_r      <= bus.sig_in;
      sync2_r      <= sync1_r;
      hist_r       <= sync2_r;
      period_vld_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (edge_det_s) begin
            state_r <= MEASURE;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        MEASURE: begin
          // An edge on the timeout cycle still counts as a valid measurement.
          if (edge_det_s) begin
            half_period_r <= cnt_inc_s[CNT_W-1:0];
            period_vld_r  <= 1'b1;
            cnt_r         <= {CNT_W{1'b0}};
            match_cnt_r   <= match_next_s;
            locked_r      <= lock_next_s;
          end else if (cnt_r == TIMEOUT_MAX) begin
            state_r     <= STALL;
            stalled_r   <= 1'b1;
            locked_r    <= 1'b0;
            match_cnt_r <= 4'd0;
          end else begin
            cnt_r <= cnt_inc_s[CNT_W-1:0];
          end
        end
        STALL: begin
          // Interval across a stall is unknown, so restart without reporting.
          if (edge_det_s) begin
            state_r   <= MEASURE;
            stalled_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
          end else begin
            cnt_r     <= cnt_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= {CNT_W{1'b0}};
          match_cnt_r <= 4'd0;
          locked_r    <= 1'b0;
          stalled_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.half_period = half_period_r;
  assign bus.period_vld  = period_vld_r;
  assign bus.locked      = locked_r;
  assign bus.stalled     = stalled_r;

endmodule

// File: tb/tb_toggle_period_meter.sv
// Directed bench for toggle_period_meter with a small, fast timebase
// (EXP_HALF=10, TOL=1, LOCK_N=4, TIMEOUT_MAX=40).
module tb_toggle_period_meter;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic sig_val = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  toggle_period_meter_if #(.CNT_W(8)) bus ();

  toggle_period_meter #(
    .CNT_W      (8),
    .EXP_HALF   (8'd10),
    .TOL        (8'd1),
    .LOCK_N     (4),
    .TIMEOUT_MAX(8'd40)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hp"},     32'(bus.half_period), 32'd0);
    chk({tag, "_vld"},    32'(bus.period_vld),  32'd0);
    chk({tag, "_locked"}, 32'(bus.locked),      32'd0);
    chk({tag, "_stalled"},32'(bus.stalled),     32'd0);
  endtask

  // Called at a negedge: flip sig_in, check the result three negedges later
  // (2-flop sync + history), then idle until gap negedges after the flip.
  task automatic toggle_expect(input string tag, input int gap, input logic exp_vld,
                               input logic [7:0] exp_hp, input logic exp_lock);
    int vld_extra;
    int stall_extra;
    sig_val    = ~sig_val;
    bus.sig_in = sig_val;
    repeat (2) @(negedge sys_clk);
    chk({tag, "_early_vld"}, 32'(bus.period_vld), 32'd0);
    @(negedge sys_clk);
    chk({tag, "_vld"},     32'(bus.period_vld),  32'(exp_vld));
    chk({tag, "_hp"},      32'(bus.half_period), 32'(exp_hp));
    chk({tag, "_locked"},  32'(bus.locked),      32'(exp_lock));
    chk({tag, "_stalled"}, 32'(bus.stalled),     32'd0);
    vld_extra   = 0;
    stall_extra = 0;
    for (int i = 3; i < gap; i++) begin
      @(negedge sys_clk);
      vld_extra   = vld_extra + int'(bus.period_vld);
      stall_extra = stall_extra + int'(bus.stalled);
    end
    if (gap > 3) begin
      chk({tag, "_extra_vld"},   32'(vld_extra),   32'd0);
      chk({tag, "_extra_stall"}, 32'(stall_extra), 32'd0);
    end
  endtask

  initial begin
    bus.sig_in = 1'b0;

    // 1: toggling under reset leaves everything clear; first edge after release is silent
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      sig_val    = ~sig_val;
      bus.sig_in = sig_val;
      @(negedge sys_clk);
      chk_all_zero("s1_in_reset");
    end
    @(negedge sys_clk);
    sig_val    = 1'b0;
    bus.sig_in = 1'b0;
    sys_rst    = 1'b0;
    repeat (4) @(negedge sys_clk);
    chk_all_zero("s1_released");
    toggle_expect("s1_first_edge", 10, 1'b0, 8'd0, 1'b0);

    // 2: steady 10-cycle half-period, lock on the 4th measurement
    toggle_expect("s2_p1", 10, 1'b1, 8'd10, 1'b0);
    toggle_expect("s2_p2", 10, 1'b1, 8'd10, 1'b0);
    toggle_expect("s2_p3", 10, 1'b1, 8'd10, 1'b0);
    toggle_expect("s2_p4", 10, 1'b1, 8'd10, 1'b1);
    toggle_expect("s2_p5", 12, 1'b1, 8'd10, 1'b1);

    // 3: 12 falls outside 10+-1, drops lock; four good ones relock
    toggle_expect("s3_long", 10, 1'b1, 8'd12, 1'b0);
    toggle_expect("s3_r1",   10, 1'b1, 8'd10, 1'b0);
    toggle_expect("s3_r2",   10, 1'b1, 8'd10, 1'b0);
    toggle_expect("s3_r3",   10, 1'b1, 8'd10, 1'b0);
    toggle_expect("s3_r4",   3,  1'b1, 8'd10, 1'b1);

    // 4: no further edge -> stall 41 cycles after the last measuring edge
    repeat (40) @(negedge sys_clk);
    chk("s4_pre_stall",  32'(bus.stalled), 32'd0);
    chk("s4_pre_locked", 32'(bus.locked),  32'd1);
    @(negedge sys_clk);
    chk("s4_stalled",     32'(bus.stalled),    32'd1);
    chk("s4_lock_lost",   32'(bus.locked),     32'd0);
    chk("s4_stall_vld",   32'(bus.period_vld), 32'd0);
    repeat (5) @(negedge sys_clk);
    chk("s4_stall_held",  32'(bus.stalled),     32'd1);
    chk("s4_hp_held",     32'(bus.half_period), 32'd10);
    toggle_expect("s4_resume", 10, 1'b0, 8'd10, 1'b0);
    toggle_expect("s4_next",   41, 1'b1, 8'd10, 1'b0);

    // 5: edge lands on the timeout cycle -> reports 41, no stall
    toggle_expect("s5_edge_at_timeout", 10, 1'b1, 8'd41, 1'b0);

    // 6: relock, then reset mid-interval clears outputs asynchronously
    toggle_expect("s6_pre1", 10, 1'b1, 8'd10, 1'b0);
    toggle_expect("s6_pre2", 10, 1'b1, 8'd10, 1'b0);
    toggle_expect("s6_pre3", 10, 1'b1, 8'd10, 1'b0);
    toggle_expect("s6_pre4", 5,  1'b1, 8'd10, 1'b1);
    #1;
    sys_rst = 1'b1;
    #1;
    chk_all_zero("s6_async_rst");
    @(negedge sys_clk);
    sig_val    = 1'b0;
    bus.sig_in = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_all_zero("s6_released");
    toggle_expect("s6_first",  7, 1'b0, 8'd0, 1'b0);
    toggle_expect("s6_second", 4, 1'b1, 8'd7, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
